// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing: latch button, run WALK / flashing DON'T-WALK from next NS-red start; countdown via PED_COUNTDOWN_EN.
// Latency: btn -> req_pending 3 clk, ns_r rise -> walk 1 clk, ns_r drop -> DON'T-WALK 1 clk.
// Backpressure: none; all outputs are lamp levels, inputs are sampled every clk.
module ped_crossing_ctrl #(
  parameter int WALK_TIME  = 3,
  parameter int FLASH_TIME = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ns_r,
  input  logic             btn,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [CNT_W-1:0] countdown
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WALK, S_FLASH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flash_ph, flash_ph_nxt;
  logic             req, req_nxt;
  logic             btn_s1, btn_s2, btn_s3;
  logic             ns_r_q;
  logic             btn_rise, ns_r_rise;
  logic             walk_done, flash_done;

  // btn is asynchronous: two sync flops, third flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
      ns_r_q <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      ns_r_q <= ns_r;
    end
  end

  assign btn_rise   = btn_s2 & ~btn_s3;
  assign ns_r_rise  = ns_r & ~ns_r_q;
  assign walk_done  = (cnt == CNT_W'(WALK_TIME - 1));
  assign flash_done = (cnt == CNT_W'(FLASH_TIME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      flash_ph <= 1'b0;
      req      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      flash_ph <= flash_ph_nxt;
      req      <= req_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    flash_ph_nxt = flash_ph;
    req_nxt      = req | btn_rise;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // only a fresh NS-red start is served, never the middle of a red phase
        if (ns_r_rise) begin
          state_nxt = S_WALK;
          cnt_nxt   = '0;
          req_nxt   = btn_rise;
        end
      end
      S_WALK: begin
        if (!ns_r) begin
          state_nxt    = req ? S_WAIT : S_IDLE;
          cnt_nxt      = '0;
          flash_ph_nxt = 1'b0;
        end else if (tick) begin
          if (walk_done) begin
            state_nxt    = S_FLASH;
            cnt_nxt      = '0;
            flash_ph_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_FLASH: begin
        if (!ns_r) begin
          state_nxt    = req ? S_WAIT : S_IDLE;
          cnt_nxt      = '0;
          flash_ph_nxt = 1'b0;
        end else if (tick) begin
          if (flash_done) begin
            state_nxt    = req ? S_WAIT : S_IDLE;
            cnt_nxt      = '0;
            flash_ph_nxt = 1'b0;
          end else begin
            cnt_nxt      = cnt + CNT_W'(1);
            flash_ph_nxt = ~flash_ph;
          end
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        cnt_nxt      = '0;
        flash_ph_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    walk        = (state == S_WALK);
    dont_walk   = (state == S_FLASH) ? flash_ph : (state != S_WALK);
    req_pending = req;
  end

`ifdef PED_COUNTDOWN_EN
  logic [CNT_W-1:0] countdown_nxt;

  always_comb begin
    case (state_nxt)
      S_WALK:  countdown_nxt = CNT_W'(WALK_TIME) - cnt_nxt + CNT_W'(FLASH_TIME);
      S_FLASH: countdown_nxt = CNT_W'(FLASH_TIME) - cnt_nxt;
      default: countdown_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) countdown <= '0;
    else        countdown <= countdown_nxt;
  end
`endif

  a_lamps_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(walk && dont_walk));
  a_walk_needs_red:  assert property (@(posedge clk) disable iff (!rst_n) walk |-> ns_r_q);

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed crossing scenarios then random traffic against an elapsed-tick model.
module tb_ped_crossing_ctrl;

  localparam int W     = 3;
  localparam int F     = 2;
  localparam int TOTAL = W + F;

  logic clk;
  logic rst_n, tick, ns_r, btn;
  logic walk, dont_walk, req_pending;
`ifdef PED_COUNTDOWN_EN
  logic [3:0] countdown;
`endif

  int n_err = 0;
  int n_chk = 0;

  // model: pending request, armed (waiting for red start), active sequence and ticks elapsed in it
  bit m_req, m_armed, m_active, m_nsq;
  int m_ticks;
  bit bh [4];

  ped_crossing_ctrl #(.WALK_TIME(W), .FLASH_TIME(F), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .ns_r        (ns_r),
    .btn         (btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .req_pending (req_pending)
`ifdef PED_COUNTDOWN_EN
    ,
    .countdown   (countdown)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_armed = 0; m_active = 0; m_nsq = 0; m_ticks = 0;
    for (int i = 0; i < 4; i++) bh[i] = 0;
  endtask

  task automatic model_edge();
    bit brise, start;
    bh[3] = bh[2]; bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = btn;
    brise = bh[2] && !bh[3];
    start = 0;
    if (m_active) begin
      if (!ns_r) begin
        m_active = 0; m_ticks = 0; m_armed = m_req;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == TOTAL) begin
          m_active = 0; m_ticks = 0; m_armed = m_req;
        end
      end
    end else if (m_armed) begin
      if (ns_r && !m_nsq) begin
        m_active = 1; m_ticks = 0; m_armed = 0; start = 1;
      end
    end else if (m_req) begin
      m_armed = 1;
    end
    if (brise) m_req = 1;
    else if (start) m_req = 0;
    m_nsq = ns_r;
  endtask

  function automatic bit e_walk();
    return m_active && (m_ticks < W);
  endfunction

  function automatic bit e_dw();
    return !m_active || ((m_ticks >= W) && (((m_ticks - W) % 2) == 0));
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("walk", {7'd0, walk}, {7'd0, e_walk()});
    chk("dont_walk", {7'd0, dont_walk}, {7'd0, e_dw()});
    chk("req_pending", {7'd0, req_pending}, {7'd0, m_req});
`ifdef PED_COUNTDOWN_EN
    chk("countdown", {4'd0, countdown}, m_active ? 8'(TOTAL - m_ticks) : 8'd0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic lamps(input string tag, input bit w, input bit dw, input bit rp);
    chk({tag, "_walk"}, {7'd0, walk}, {7'd0, w});
    chk({tag, "_dont_walk"}, {7'd0, dont_walk}, {7'd0, dw});
    chk({tag, "_req_pending"}, {7'd0, req_pending}, {7'd0, rp});
  endtask

  initial begin
    bit walk_seen, dw_low_seen;
    int ph_left, tcnt;

    rst_n = 1'b0; tick = 1'b0; ns_r = 1'b0; btn = 1'b0;
    model_reset();
    #12;
    lamps("reset", 0, 1, 0);
`ifdef PED_COUNTDOWN_EN
    chk("reset_countdown", {4'd0, countdown}, 8'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // full cycle: press during green, then red starts
    btn = 1'b1;
    idle(2);
    chk("t2_req_after_2clk", {7'd0, req_pending}, 8'd0);
    cyc();
    chk("t2_req_after_3clk", {7'd0, req_pending}, 8'd1);
    btn = 1'b0;
    idle(4);
    ns_r = 1'b1;
    cyc();
    lamps("t2_walk_start", 1, 0, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t2_cd5", {4'd0, countdown}, 8'd5);
`endif
    idle(3); pulse_tick();
    lamps("t2_tick1", 1, 0, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t2_cd4", {4'd0, countdown}, 8'd4);
`endif
    idle(3); pulse_tick();
    lamps("t2_tick2", 1, 0, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t2_cd3", {4'd0, countdown}, 8'd3);
`endif
    idle(3); pulse_tick();
    lamps("t2_flash_on", 0, 1, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t2_cd2", {4'd0, countdown}, 8'd2);
`endif
    idle(3); pulse_tick();
    lamps("t2_flash_off", 0, 0, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t2_cd1", {4'd0, countdown}, 8'd1);
`endif
    idle(3); pulse_tick();
    lamps("t2_done", 0, 1, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t2_cd0", {4'd0, countdown}, 8'd0);
`endif

    // two light cycles without any press
    walk_seen = 0; dw_low_seen = 0;
    for (int c = 0; c < 4; c++) begin
      ns_r = (c % 2) == 1;
      for (int i = 0; i < 25; i++) begin
        tick = (i % 5) == 4;
        cyc();
        tick = 1'b0;
        if (walk !== 1'b0) walk_seen = 1;
        if (dont_walk !== 1'b1) dw_low_seen = 1;
      end
    end
    chk("t3_walk_never", {7'd0, walk_seen}, 8'd0);
    chk("t3_dont_walk_const", {7'd0, dw_low_seen}, 8'd0);

    // abort: red ends one tick into WALK
    ns_r = 1'b0;
    idle(3);
    btn = 1'b1; idle(4); btn = 1'b0; idle(3);
    ns_r = 1'b1;
    cyc();
    chk("t4_walk_start", {7'd0, walk}, 8'd1);
    idle(2); pulse_tick(); idle(2);
    ns_r = 1'b0;
    cyc();
    lamps("t4_abort", 0, 1, 0);
    idle(3);
    ns_r = 1'b1;
    cyc();
    chk("t4_idle_no_restart", {7'd0, walk}, 8'd0);

    // late press while red already on
    btn = 1'b1; idle(4); btn = 1'b0;
    chk("t5_req_mid_red", {7'd0, req_pending}, 8'd1);
    idle(2); pulse_tick(); idle(2);
    chk("t5_no_walk_mid_red", {7'd0, walk}, 8'd0);
    ns_r = 1'b0;
    idle(4);
    ns_r = 1'b1;
    cyc();
    lamps("t5_walk_next_red", 1, 0, 0);
    for (int i = 0; i < W; i++) begin
      idle(3); pulse_tick();
    end
    // press during FLASH
    btn = 1'b1; idle(4); btn = 1'b0;
    chk("t5_req_in_flash", {7'd0, req_pending}, 8'd1);
    pulse_tick(); idle(2); pulse_tick();
    lamps("t5_flash_to_wait", 0, 1, 1);
    idle(3); pulse_tick(); idle(3);
    chk("t5_wait_holds", {7'd0, walk}, 8'd0);
    ns_r = 1'b0;
    idle(3);
    ns_r = 1'b1;
    cyc();
    lamps("t5_walk_after_flash_press", 1, 0, 0);

    // async reset in the middle of WALK with a pending request
    btn = 1'b1; idle(4); btn = 1'b0; idle(2); pulse_tick();
    lamps("t1_before_reset", 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    lamps("t1_async_reset", 0, 1, 0);
`ifdef PED_COUNTDOWN_EN
    chk("t1_reset_countdown", {4'd0, countdown}, 8'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    ns_r = 1'b0; tick = 1'b0; btn = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // random traffic: varied red/green lengths, jittery ticks, random button activity
    ph_left = 10; tcnt = 0;
    for (int i = 0; i < 2500; i++) begin
      if (ph_left == 0) begin
        ns_r = ~ns_r;
        ph_left = $urandom_range(3, 45);
      end else begin
        ph_left--;
      end
      tcnt = (tcnt == 4) ? 0 : tcnt + 1;
      tick = (tcnt == 0) || ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 15) == 0) btn = ~btn;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
